// File: rtl/pad_io_pkg.sv
// Shared types and width helpers for the pad-side I/O bridge.
package pad_io_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_HOLD} rd_state_t;

  // Counter/pointer width, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pad_io_fifo.sv
// Show-ahead FIFO, full/empty decoded from a registered occupancy count.
module pad_io_fifo
  import pad_io_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = clog2w(DEPTH);
  localparam int CW = clog2w(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is reset too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pad_io_bridge.sv
// Pad-to-core bridge: beat packer into a FIFO, start/done pulse and flag
// conditioning, and a handshaked single-word read port.
module pad_io_bridge
  import pad_io_pkg::*;
#(
  parameter int PAD_IN_W = 8,
  parameter int CORE_W   = 16,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_input,
  input  logic [PAD_IN_W-1:0] X_load,
  output logic                in_rdy,
  input  logic                start_in,
  input  logic                read_n,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   read_data,
  output logic                ry,
  output logic                finish,
  output logic                ovf,
  output logic                in_valid,
  output logic [CORE_W-1:0]   in_data,
  input  logic                in_ready,
  output logic                start,
  input  logic                done,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_ack,
  input  logic [DATA_W-1:0]   rd_data
);

  localparam int BEATS = CORE_W / PAD_IN_W;
  localparam int BW    = clog2w(BEATS);

  logic [BW-1:0]     beat_cnt;
  logic [CORE_W-1:0] partial, word;
  logic              fifo_full, fifo_empty;
  logic              accept, last_beat, start_q, start_edge;
  rd_state_t         rd_state;

  assign in_rdy     = !fifo_full;
  assign in_valid   = !fifo_empty;
  assign accept     = valid_input && in_rdy;
  assign last_beat  = (beat_cnt == BW'(BEATS - 1));
  assign start_edge = start_in && !start_q;

  // Current beat merged into the partial word; on the last beat this is the push word.
  always_comb begin
    word = partial;
    word[int'(beat_cnt)*PAD_IN_W +: PAD_IN_W] = X_load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      partial  <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      partial  <= word;
      beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
    end
  end

  pad_io_fifo #(.W(CORE_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && last_beat),
    .push_data (word),
    .pop       (in_valid && in_ready),
    .head      (in_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A start edge clears the sticky flags and beats a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      start   <= 1'b0;
      finish  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      start_q <= start_in;
      start   <= start_edge;
      if (start_edge) begin
        finish <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (done) finish <= 1'b1;
        if (valid_input && !in_rdy) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state  <= RD_IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      read_data <= '0;
      ry        <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: if (!read_n) begin
          rd_addr  <= r_addr;
          rd_req   <= 1'b1;
          rd_state <= RD_REQ;
        end
        RD_REQ: if (rd_ack) begin
          read_data <= rd_data;
          rd_req    <= 1'b0;
          ry        <= 1'b1;
          rd_state  <= RD_HOLD;
        end
        RD_HOLD: if (read_n) begin
          ry       <= 1'b0;
          rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_io_bridge.sv
// Directed bench for pad_io_bridge at default parameters.
module tb_pad_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_input;
  logic [7:0]  X_load;
  logic        in_rdy;
  logic        start_in;
  logic        read_n;
  logic [7:0]  r_addr;
  logic [8:0]  read_data;
  logic        ry, finish, ovf, in_valid;
  logic [15:0] in_data;
  logic        in_ready, start, done, rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ack;
  logic [8:0]  rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  pad_io_bridge dut (
    .clk(clk), .rst(rst), .valid_input(valid_input), .X_load(X_load),
    .in_rdy(in_rdy), .start_in(start_in), .read_n(read_n), .r_addr(r_addr),
    .read_data(read_data), .ry(ry), .finish(finish), .ovf(ovf),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 1);
    chk({tag, "_in_valid"}, in_valid, 0);
    chk({tag, "_in_data"}, in_data, 0);
    chk({tag, "_ry"}, ry, 0);
    chk({tag, "_read_data"}, read_data, 0);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    rst = 1'b0; valid_input = 0; X_load = '0; start_in = 0; read_n = 1;
    r_addr = '0; in_ready = 0; done = 0; rd_ack = 0; rd_data = '0;
    tick(); tick();
    chk_reset("rst");
    rst = 1'b1;
    tick();

    // Two beats pack LSB-first, then pop.
    in_ready = 1;
    valid_input = 1; X_load = 8'h34; tick();
    X_load = 8'h12; tick();
    valid_input = 0;
    chk("pack_valid", in_valid, 1);
    chk("pack_data", in_data, 16'h1234);
    tick();
    chk("pack_popped", in_valid, 0);

    // Fill the FIFO, overflow, pop one, refill, drain.
    in_ready = 0;
    for (int i = 0; i < 8; i++) begin
      valid_input = 1; X_load = 8'h10 + 8'(i); tick();
    end
    valid_input = 0;
    chk("full_rdy", in_rdy, 0);
    chk("full_head", in_data, 16'h1110);
    chk("full_no_ovf", ovf, 0);
    valid_input = 1; X_load = 8'hAA; tick();
    valid_input = 0;
    chk("drop_ovf", ovf, 1);
    chk("drop_rdy", in_rdy, 0);
    in_ready = 1; tick(); in_ready = 0;
    chk("pop_rdy", in_rdy, 1);
    chk("pop_head", in_data, 16'h1312);
    valid_input = 1; X_load = 8'h55; tick();
    X_load = 8'h66; tick();
    valid_input = 0;
    chk("refill_rdy", in_rdy, 0);
    in_ready = 1;
    chk("drain0", in_data, 16'h1312); tick();
    chk("drain1", in_data, 16'h1514); tick();
    chk("drain2", in_data, 16'h1716); tick();
    chk("drain3", in_data, 16'h6655); tick();
    in_ready = 0;
    chk("drain_empty", in_valid, 0);

    // Read handshake.
    read_n = 0; r_addr = 8'h5A; tick();
    chk("rd_req", rd_req, 1);
    chk("rd_addr", rd_addr, 8'h5A);
    chk("rd_no_ry", ry, 0);
    tick(); tick();
    chk("rd_req_wait", rd_req, 1);
    rd_ack = 1; rd_data = 9'h1FF; tick();
    rd_ack = 0; rd_data = '0;
    chk("rd_ry", ry, 1);
    chk("rd_data", read_data, 9'h1FF);
    chk("rd_req_drop", rd_req, 0);
    tick(); tick();
    chk("rd_hold_ry", ry, 1);
    chk("rd_hold_data", read_data, 9'h1FF);
    read_n = 1; tick();
    chk("rd_release", ry, 0);
    rd_ack = 1; rd_data = 9'h0AA; tick();
    rd_ack = 0; rd_data = '0;
    chk("rd_stray_ack", read_data, 9'h1FF);
    chk("rd_stray_req", rd_req, 0);

    // Done sets finish; start edge gives one pulse and clears flags.
    done = 1; tick(); done = 0;
    chk("done_finish", finish, 1);
    tick();
    chk("done_hold", finish, 1);
    start_in = 1; tick();
    chk("start_pulse", start, 1);
    chk("start_clr_finish", finish, 0);
    chk("start_clr_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("start_once", start, 0);
    end
    start_in = 0; tick();

    // Same-cycle done and start edge: clear wins.
    start_in = 1; done = 1; tick();
    start_in = 0; done = 0;
    chk("clr_wins_finish", finish, 0);
    chk("clr_wins_start", start, 1);

    // Reset mid-REQ with a partial word.
    done = 1; tick(); done = 0;
    valid_input = 1; X_load = 8'h77; tick(); valid_input = 0;
    read_n = 0; r_addr = 8'h33; tick();
    chk("mid_req", rd_req, 1);
    chk("mid_finish", finish, 1);
    rst = 0; #1;
    chk_reset("rst2");
    tick();
    rst = 1; read_n = 1;
    tick();
    valid_input = 1; X_load = 8'h01; tick();
    X_load = 8'h02; tick();
    valid_input = 0;
    chk("post_rst_valid", in_valid, 1);
    chk("post_rst_data", in_data, 16'h0201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_io_bridge.md
# pad_io_bridge

Parametrised pad-side interface between the padframe wrapper and the compute core. It packs narrow pad input beats into core-width words through a small FIFO with flow control. It also runs a handshaked single-word read port toward the core, and turns the `start_in` and `done` levels into clean pulses and sticky flags. It replaces the direct pad-to-core wiring: the core sees only registered, handshaked traffic.

## Interface
- `PAD_IN_W`, default 8: pad input beat width.
- `CORE_W`, default 16: core input word width. Must be an integer multiple of `PAD_IN_W`. `BEATS = CORE_W/PAD_IN_W`, and `BEATS >= 1`.
- `DEPTH`, default 4: input FIFO depth in words. Power of two, ≥ 2.
- `ADDR_W`, default 8: read address width.
- `DATA_W`, default 9: read data width.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_input`  in  1  pad beat valid.
- `X_load`  in  `PAD_IN_W`  pad beat data.
- `in_rdy`  out  1  bridge can accept a beat.
- `start_in`  in  1  pad start level.
- `read_n`  in  1  pad read request, active-low.
- `r_addr`  in  `ADDR_W`  pad read address.
- `read_data`  out  `DATA_W`  registered read result.
- `ry`  out  1  read result valid.
- `finish`  out  1  sticky done flag.
- `ovf`  out  1  sticky dropped-beat flag.
- `in_valid`  out  1  core-side FIFO head valid.
- `in_data`  out  `CORE_W`  FIFO head word (show-ahead).
- `in_ready`  in  1  core pops the head.
- `start`  out  1  one-cycle start pulse to the core.
- `done`  in  1  core completion pulse.
- `rd_req`  out  1  core read request.
- `rd_addr`  out  `ADDR_W`  latched read address.
- `rd_ack`  in  1  core read data valid.
- `rd_data`  in  `DATA_W`  core read data.

## Operation
**Input packer**
- A beat is accepted when `valid_input && in_rdy`. `in_rdy = !fifo_full`, decoded from the registered count.
- Beats are packed LSB-first: beat k lands in bits `[k*PAD_IN_W +: PAD_IN_W]`.
- A beat counter runs 0..`BEATS-1` and wraps to 0 on the last beat.
- The last beat pushes `{X_load, partial}` into the FIFO on that edge. Room is guaranteed because `in_rdy` was high.
- `valid_input && !in_rdy`: the beat is dropped, the beat counter is unchanged, and `ovf` is set.
- FIFO pop occurs when `in_valid && in_ready`.
- Simultaneous push and pop leave the count unchanged.
- Pop and full in the same cycle: no push is possible that cycle because `in_rdy` was low.

**Start and done**
- A rising edge of `start_in`, detected against its registered previous value, drives `start` high for exactly 1 cycle.
- The same edge clears `finish` and `ovf`. A level held high produces no further pulses.
- `done` sets `finish`, which holds until the next start edge.
- `done` and the start edge in the same cycle: clear wins.

**Read FSM**
- IDLE: when `read_n` is sampled low, latch `r_addr` into `rd_addr` and go to REQ.
- REQ: `rd_req` is high. On `rd_ack`, register `rd_data` into `read_data`, drop `rd_req`, and go to HOLD.
- HOLD: `ry` is high and `read_data` is stable. When `read_n` is sampled high, go to IDLE.
- `rd_ack` outside REQ is ignored.
- `read_n` rising while in REQ has no effect: the transaction completes, and HOLD exits at the next cycle in which `read_n` is sampled high.

**Reset**
- Asserting `rst` at any time, including mid-packing or mid-read, returns every register to its reset value. Partial beats and FIFO contents are discarded.
- Reset values: `read_data=0`, `ry=0`, `finish=0`, `ovf=0`, `in_valid=0`, `in_data=0`, `start=0`, `rd_req=0`, `rd_addr=0`, FSM in IDLE, beat counter 0.
- `in_rdy=1` during and after reset, because the FIFO is empty.

## Timing
- Last beat accepted at edge N → `in_valid=1` and `in_data` valid from cycle N+1.
- A pop at edge N exposes the next head at N+1. Pop from full at N → `in_rdy=1` at N+1.
- `read_n` sampled low at edge N → `rd_req=1` and `rd_addr` valid at N+1.
- `rd_ack` at edge M → `read_data` and `ry=1` at M+1, with `rd_req=0` at M+1.
- `read_n` sampled high at edge P in HOLD → `ry=0` at P+1. A new request can be sampled at P+1.
- Start edge sampled at N → `start=1` during cycle N+1 only.
- All outputs are registered, except `in_rdy` and `in_valid`, which are decoded from the registered count.

## Structure
- Package `pad_io_pkg` holds:
  - the read FSM state enum: `RD_IDLE`, `RD_REQ`, `RD_HOLD`;
  - a `clog2`-based width helper for the FIFO pointers and the beat counter.
- Sub-module `pad_io_fifo`: a synchronous show-ahead FIFO with parameters `W` and `DEPTH`, async active-low reset, full/empty from a count register, and push/pop ports.
- Packer, start/done logic and read FSM live in `pad_io_bridge`.

## Test plan
Defaults throughout: `PAD_IN_W=8`, `CORE_W=16`, `DEPTH=4`.
- Beats 0x34 then 0x12, with `in_ready=1` → `in_valid=1` with `in_data=0x1234` in the cycle after the second beat; popped the following cycle.
- `in_ready=0`, 8 beats → `in_rdy=0` after the 8th beat; 9th beat 0xAA → dropped, `ovf=1`. One pop → `in_rdy=1` next cycle, and the next 2 beats form a word.
- `read_n=0`, `r_addr=0x5A`; core acks 3 cycles later with 0x1FF → `rd_addr=0x5A`, `read_data=0x1FF`, `ry=1` until `read_n=1`, then `ry=0` one cycle later.
- `start_in` 0→1 held 5 cycles → exactly one `start` pulse; `finish` and `ovf` previously 1 are cleared.
- `done` pulse → `finish=1` held. `rst=0` asserted mid-REQ with one beat packed → all outputs at reset values; after release, 2 beats 0x01, 0x02 yield `in_data=0x0201`.
